// File: rtl/sisc_pkg.sv
// SISC shared definitions: field positions, widths,
// opcode map and fetch FSM encoding.
package sisc_pkg;

    localparam int PC_W    = 16;
    localparam int IR_W    = 32;
    localparam int OP_W    = 4;
    localparam int MM_W    = 4;
    localparam int IMM_W   = 16;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int MM_MSB  = 27;
    localparam int MM_LSB  = 24;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = $clog2(TIMEOUT);

    localparam logic [OP_W-1:0] OP_NOOP = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_AND  = 4'h3;
    localparam logic [OP_W-1:0] OP_OR   = 4'h4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h6;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h7;
    localparam logic [OP_W-1:0] OP_BRA  = 4'h8;
    localparam logic [OP_W-1:0] OP_BRR  = 4'h9;
    localparam logic [OP_W-1:0] OP_LOD  = 4'hA;
    localparam logic [OP_W-1:0] OP_STR  = 4'hB;
    localparam logic [OP_W-1:0] OP_MOV  = 4'hC;
    localparam logic [OP_W-1:0] OP_LDI  = 4'hD;
    localparam logic [OP_W-1:0] OP_SWAP = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sisc_pc_next.sv
// Next-PC selection: sequential, absolute or relative,
// all arithmetic modulo 2^PC_W.
module sisc_pc_next
    import sisc_pkg::*;
(
    input  logic [PC_W-1:0]  pc,
    input  logic [IMM_W-1:0] imm,
    input  logic             pc_sel,
    input  logic             br_sel,
    output logic [PC_W-1:0]  pc_next
);

    logic [PC_W-1:0] imm_ext;

    assign imm_ext = PC_W'($signed(imm));

    always_comb begin
        pc_next = pc + PC_W'(1);
        case ({pc_sel, br_sel})
            2'b11:   pc_next = imm_ext;
            2'b10:   pc_next = pc + imm_ext;
            default: pc_next = pc + PC_W'(1);
        endcase
    end

endmodule

// File: rtl/sisc_fetch.sv
// SISC fetch unit: PC register plus single-outstanding
// instruction fetch with ack timeout.
module sisc_fetch
    import sisc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_f,
    input  logic             pc_write,
    input  logic             pc_sel,
    input  logic             br_sel,
    input  logic             ir_load,
    input  logic [IR_W-1:0]  im_rdata,
    input  logic             im_ack,
    output logic             im_req,
    output logic [PC_W-1:0]  im_addr,
    output logic [IR_W-1:0]  ir,
    output logic [OP_W-1:0]  opcode,
    output logic [MM_W-1:0]  mm,
    output logic [IMM_W-1:0] imm,
    output logic [PC_W-1:0]  pc_out,
    output logic             busy,
    output logic             fetch_err
);

    fetch_state_t     state;
    fetch_state_t     state_nx;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic             start;
    logic             take;
    logic             tmo;

    sisc_pc_next u_pc_next (
        .pc      (pc),
        .imm     (imm),
        .pc_sel  (pc_sel),
        .br_sel  (br_sel),
        .pc_next (pc_nx)
    );

    always_ff @(posedge clk) begin
        if (rst_f) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        take     = 1'b0;
        tmo      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ir_load) begin
                    start    = 1'b1;
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (im_ack) begin
                    take     = 1'b1;
                    state_nx = ST_DONE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    tmo      = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                // a load arriving in DONE starts the next fetch directly
                if (ir_load) begin
                    start    = 1'b1;
                    state_nx = ST_WAIT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            pc        <= '0;
            ir        <= '0;
            im_addr   <= '0;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (pc_write) pc <= pc_nx;
            if (start) begin
                im_addr  <= pc;
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (take) begin
                ir <= im_rdata;
            end else if (tmo) begin
                ir        <= {OP_NOOP, {(IR_W - OP_W){1'b0}}};
                fetch_err <= 1'b1;
            end
        end
    end

    assign im_req = (state == ST_WAIT);
    assign busy   = (state == ST_WAIT);
    assign pc_out = pc;
    assign opcode = ir[OP_MSB:OP_LSB];
    assign mm     = ir[MM_MSB:MM_LSB];
    assign imm    = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_sisc_fetch.sv
// Scoreboard bench for sisc_fetch: directed fetches, PC
// arithmetic, timeout, reset abort and back-to-back loads.
module tb_sisc_fetch;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        pc_write = 1'b0;
    logic        pc_sel = 1'b0;
    logic        br_sel = 1'b0;
    logic        ir_load = 1'b0;
    logic [31:0] im_rdata = '0;
    logic        im_ack = 1'b0;
    logic        im_req;
    logic [15:0] im_addr;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] imm;
    logic [15:0] pc_out;
    logic        busy;
    logic        fetch_err;

    sisc_fetch dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .pc_write  (pc_write),
        .pc_sel    (pc_sel),
        .br_sel    (br_sel),
        .ir_load   (ir_load),
        .im_rdata  (im_rdata),
        .im_ack    (im_ack),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .ir        (ir),
        .opcode    (opcode),
        .mm        (mm),
        .imm       (imm),
        .pc_out    (pc_out),
        .busy      (busy),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [3:0]  op;
        logic [3:0]  mm;
        logic [15:0] imm;
        logic        err;
        logic [15:0] addr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   req_rises = 0;
    logic prev_busy = 1'b0;
    logic prev_req = 1'b0;
    logic prev_rst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] i, input logic [3:0] o,
                        input logic [3:0] m, input logic [15:0] im,
                        input logic e, input logic [15:0] a);
        exp_t x;
        x.ir = i; x.op = o; x.mm = m; x.imm = im; x.err = e; x.addr = a;
        sb.push_back(x);
    endtask

    // completion monitor: a fetch finishes when busy falls outside reset
    always @(negedge clk) begin
        exp_t x;
        if (prev_busy && !busy && !prev_rst) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: ir 0x%0h, no fetch expected", ir);
            end else begin
                x = sb.pop_front();
                chk("mon_ir", ir, x.ir);
                chk("mon_opcode", 32'(opcode), 32'(x.op));
                chk("mon_mm", 32'(mm), 32'(x.mm));
                chk("mon_imm", 32'(imm), 32'(x.imm));
                chk("mon_err", 32'(fetch_err), 32'(x.err));
                chk("mon_addr", 32'(im_addr), 32'(x.addr));
            end
        end
        if (im_req && !prev_req) req_rises++;
        prev_busy = busy;
        prev_req  = im_req;
        prev_rst  = rst_f;
    end

    task automatic do_fetch(input logic [31:0] data, input logic [3:0] op,
                            input logic [3:0] m, input logic [15:0] im,
                            input int delay, input logic [15:0] addr,
                            input logic err, input logic pw);
        int n;
        push(data, op, m, im, err, addr);
        ir_load = 1'b1; pc_write = pw; pc_sel = 1'b0;
        tick();
        ir_load = 1'b0; pc_write = 1'b0;
        chk("req_up", 32'(im_req), 32'd1);
        chk("fetch_addr", 32'(im_addr), 32'(addr));
        if (delay == 0) begin
            n = 0;
            for (int k = 0; k < 40 && im_req; k++) begin
                n++;
                tick();
            end
            chk("req_cycles", 32'(n), 32'd16);
        end else begin
            repeat (delay - 1) tick();
            im_rdata = data; im_ack = 1'b1;
            tick();
            im_ack = 1'b0;
        end
        chk("busy_done", 32'(busy), 32'd0);
    endtask

    task automatic pcw(input logic sel, input logic br);
        pc_write = 1'b1; pc_sel = sel; br_sel = br;
        tick();
        pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        rst_f = 1'b1;
        tick(); tick();
        rst_f = 1'b0;
        chk("rst_pc", 32'(pc_out), 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_req", 32'(im_req), 32'h0);
        chk("rst_addr", 32'(im_addr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(fetch_err), 32'h0);

        // minimum latency fetch, ack two cycles after load
        do_fetch(32'h81230005, 4'h8, 4'h1, 16'h0005, 2, 16'h0000, 1'b0, 1'b0);
        im_rdata = 32'hFFFFFFFF; im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        chk("ack_in_done", ir, 32'h81230005);

        // PC arithmetic and wrap
        do_fetch(32'h00000010, 4'h0, 4'h0, 16'h0010, 2, 16'h0000, 1'b0, 1'b0);
        pcw(1'b1, 1'b1);
        chk("pc_abs_10", 32'(pc_out), 32'h0010);
        do_fetch(32'h8000FFFE, 4'h8, 4'h0, 16'hFFFE, 1, 16'h0010, 1'b0, 1'b0);
        pcw(1'b1, 1'b0);
        chk("pc_rel", 32'(pc_out), 32'h000E);
        pcw(1'b1, 1'b1);
        chk("pc_abs", 32'(pc_out), 32'hFFFE);
        pcw(1'b0, 1'b0);
        chk("pc_seq", 32'(pc_out), 32'hFFFF);
        pcw(1'b0, 1'b0);
        chk("pc_wrap", 32'(pc_out), 32'h0000);

        // load and pc_write together: fetch uses pre-update PC
        repeat (4) pcw(1'b0, 1'b0);
        chk("pc_4", 32'(pc_out), 32'h0004);
        do_fetch(32'h2A000007, 4'h2, 4'hA, 16'h0007, 2, 16'h0004, 1'b0, 1'b1);
        chk("pc_5", 32'(pc_out), 32'h0005);

        // timeout, then sticky error over a good fetch
        do_fetch(32'h0, 4'h0, 4'h0, 16'h0, 0, 16'h0005, 1'b1, 1'b0);
        chk("tmo_err", 32'(fetch_err), 32'h1);
        chk("tmo_ir", ir, 32'h0);
        do_fetch(32'h31110042, 4'h3, 4'h1, 16'h0042, 3, 16'h0005, 1'b1, 1'b0);
        chk("err_sticky", 32'(fetch_err), 32'h1);

        // reset in WAIT, dominating pc_write/ir_load, late ack
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        tick();
        rst_f = 1'b1; pc_write = 1'b1; ir_load = 1'b1;
        tick();
        rst_f = 1'b0; pc_write = 1'b0; ir_load = 1'b0;
        chk("abort_req", 32'(im_req), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_pc", 32'(pc_out), 32'h0);
        im_rdata = 32'hDEADBEEF; im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        chk("late_ack_ir", ir, 32'h0);
        chk("late_ack_req", 32'(im_req), 32'h0);
        chk("late_ack_err", 32'(fetch_err), 32'h0);
        chk("late_ack_addr", 32'(im_addr), 32'h0);

        // spurious load in WAIT, back-to-back load in DONE
        r0 = req_rises;
        push(32'h11000001, 4'h1, 4'h1, 16'h0001, 1'b0, 16'h0000);
        ir_load = 1'b1;
        tick();
        chk("b2b_addr0", 32'(im_addr), 32'h0000);
        pc_write = 1'b1; pc_sel = 1'b0;
        tick();
        ir_load = 1'b0; pc_write = 1'b0;
        im_rdata = 32'h11000001; im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        chk("b2b_busy0", 32'(busy), 32'h0);
        push(32'hF0000000, 4'hF, 4'h0, 16'h0000, 1'b0, 16'h0001);
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        chk("b2b_req1", 32'(im_req), 32'h1);
        chk("b2b_addr1", 32'(im_addr), 32'h0001);
        im_rdata = 32'hF0000000; im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        repeat (3) tick();
        chk("b2b_requests", 32'(req_rises - r0), 32'd2);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sisc_fetch.md
SISC_FETCH -- requirements
Module: sisc_fetch

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_f  input  1  reset; synchronous, active-high.
REQ-003 pc_write  input  1  from ctrl; load PC with next-PC value this cycle.
REQ-004 pc_sel  input  1  from ctrl; 0 = sequential (PC+1), 1 = branch target.
REQ-005 br_sel  input  1  from ctrl; with pc_sel=1: 1 = absolute (imm), 0 = relative (PC+imm).
REQ-006 ir_load  input  1  from ctrl; start instruction fetch at current PC.
REQ-007 im_rdata  input  32  instruction memory read data, valid when im_ack=1.
REQ-008 im_ack  input  1  instruction memory acknowledge, single-cycle pulse.
REQ-009 im_req  output  1  instruction memory request, held until ack or timeout.
REQ-010 im_addr  output  16  word address of outstanding fetch.
REQ-011 ir  output  32  instruction register.
REQ-012 opcode  output  4  ir[31:28], to ctrl.
REQ-013 mm  output  4  ir[27:24], condition/addressing field, to ctrl.
REQ-014 imm  output  16  ir[15:0], branch/immediate field.
REQ-015 pc_out  output  16  current PC.
REQ-016 busy  output  1  fetch outstanding; ctrl stalls while high.
REQ-017 fetch_err  output  1  sticky fetch-timeout flag.

Function
REQ-018 Next PC: pc_sel=0 -> PC+1; pc_sel=1,br_sel=1 -> imm; pc_sel=1,br_sel=0 -> PC+sign-extended imm; all 16-bit modulo, wrap silently (0xFFFF+1 = 0x0000).
REQ-019 PC updates only on cycles with pc_write=1, independent of fetch FSM state; imm source is the current ir value.
REQ-020 FSM states: IDLE, WAIT, DONE; encoding from shared package.
REQ-021 IDLE: ir_load=1 -> capture PC into im_addr, assert im_req next cycle, busy=1, go WAIT; otherwise stay.
REQ-022 ir_load and pc_write in the same cycle: fetch address is the pre-update PC.
REQ-023 WAIT: im_req=1, im_addr stable; im_ack=1 -> ir <= im_rdata, im_req=0, go DONE.
REQ-024 WAIT: 16-cycle wait counter from request assertion; expiry without ack -> ir <= 0x00000000 (NOOP), fetch_err=1, im_req=0, go DONE.
REQ-025 DONE: busy=0, ir stable; next cycle go IDLE; ir_load in DONE is treated as IDLE ir_load (back-to-back fetch, no lost request).
REQ-026 ir_load while in WAIT is ignored; no second request queued.
REQ-027 im_ack while in IDLE or DONE is ignored; ir unchanged.
REQ-028 Minimum fetch latency: ir_load at cycle N, ack at N+2 -> ir valid, busy=0 at N+3.
REQ-029 opcode, mm, imm are pure slices of ir, no added latency.

Reset
REQ-030 rst_f=1 at a rising edge: PC=0x0000, ir=0, im_req=0, im_addr=0, busy=0, fetch_err=0, wait counter=0, state IDLE.
REQ-031 Reset mid-fetch aborts the transaction; im_req drops the following cycle; a late im_ack is ignored.
REQ-032 rst_f dominates pc_write and ir_load in the same cycle.

Structure
REQ-033 Shared package sisc_pkg holds opcode constants (NOOP..HLT), field bit positions, PC/IR widths, FSM state encoding, timeout constant (16).
REQ-034 One sub-module, sisc_pc_next: combinational next-PC mux and adder per REQ-018; PC register and fetch FSM stay in sisc_fetch.

Verification
REQ-035 Reset, then ir_load with ack 2 cycles later, im_rdata=0x81230005 -> ir=0x81230005, opcode=8, mm=1, im_addr=0x0000, busy low at cycle 3.
REQ-036 PC=0x0010, ir imm=0xFFFE, pc_sel=1, br_sel=0, pc_write=1 -> PC=0x000E; br_sel=1 -> PC=0xFFFE; then pc_sel=0 write -> PC=0xFFFF, again -> 0x0000.
REQ-037 ir_load and pc_write together at PC=0x0004 -> im_addr=0x0004, pc_out=0x0005.
REQ-038 ir_load, never ack -> im_req high exactly 16 cycles, then ir=0, fetch_err=1, busy=0; fetch_err stays 1 over subsequent good fetches until reset.
REQ-039 rst_f asserted in WAIT, ack one cycle after reset -> im_req=0, ir=0, state IDLE, ack ignored.
REQ-040 ir_load in DONE, and spurious ir_load during WAIT -> exactly two memory requests, second at updated PC.
